// File: rtl/ofdm_symbol_framer.sv
// OFDM symbol framer: drops preamble and cyclic prefixes, emits FFT_LEN-sample symbols.
// Optional statistics counters are built when OFDM_SYMBOL_FRAMER_STATS_EN is defined.
module ofdm_symbol_framer #(
    parameter int WIDTH_SAMPLE = 16,
    parameter int WIDTH_PHASE  = 32,
    parameter int FFT_LEN      = 64,
    parameter int CP_LEN       = 16,
    parameter int SKIP_DEFAULT = 192,
    parameter int SR_SKIP      = 6,
    parameter int SR_NUM_SYM   = 7
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      set_stb,
    input  logic [7:0]                set_addr,
    input  logic [31:0]               set_data,
    input  logic [2*WIDTH_SAMPLE-1:0] i_tdata,
    input  logic                      i_tlast,
    input  logic                      i_tvalid,
    output logic                      i_tready,
    input  logic [WIDTH_PHASE-1:0]    phase_tdata,
    input  logic                      phase_tvalid,
    output logic                      phase_tready,
    output logic [2*WIDTH_SAMPLE-1:0] o_tdata,
    output logic [WIDTH_PHASE-1:0]    o_phase,
    output logic                      o_tlast,
    output logic                      o_tvalid,
    input  logic                      o_tready,
    output logic                      frame_done,
    output logic [15:0]               stat_frames,
    output logic [15:0]               stat_resyncs
);

    // Handshake: a beat moves on a port when its valid and ready are both high at
    // the rising clock edge; o_tvalid and its payload hold steady until o_tready.
    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CP, S_SYM} state_t;

    state_t                 state;
    logic [9:0]             skip_reg;
    logic [11:0]            num_sym_reg;
    logic [9:0]             frame_skip;
    logic [11:0]            frame_num_sym;
    logic [9:0]             skip_cnt;
    logic [6:0]             samp_cnt;
    logic [11:0]            sym_cnt;
    logic [WIDTH_PHASE-1:0] phase_reg;
    logic [9:0]             skip_eff;
    logic                   xfer;
    logic                   marker;
    logic                   unused_set_bits;

    assign unused_set_bits = ^set_data[31:12];

    assign i_tready     = (state == S_SYM) ? (~o_tvalid | o_tready) : 1'b1;
    assign phase_tready = i_tready;
    assign xfer         = i_tvalid & phase_tvalid & i_tready;
    assign marker       = xfer & i_tlast;
    assign skip_eff     = (skip_reg == 10'd0) ? 10'd1 : skip_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skip_reg    <= 10'(SKIP_DEFAULT);
            num_sym_reg <= 12'd0;
        end else if (set_stb) begin
            if (set_addr == 8'(SR_SKIP))    skip_reg    <= set_data[9:0];
            if (set_addr == 8'(SR_NUM_SYM)) num_sym_reg <= set_data[11:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            frame_skip    <= 10'd1;
            frame_num_sym <= 12'd0;
            skip_cnt      <= 10'd0;
            samp_cnt      <= 7'd0;
            sym_cnt       <= 12'd0;
            phase_reg     <= '0;
            o_tdata       <= '0;
            o_phase       <= '0;
            o_tlast       <= 1'b0;
            o_tvalid      <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (o_tvalid && o_tready) o_tvalid <= 1'b0;

            // A marker restarts the frame from any state; settings are captured here.
            if (marker) begin
                phase_reg     <= phase_tdata;
                frame_skip    <= skip_eff;
                frame_num_sym <= num_sym_reg;
                skip_cnt      <= 10'd1;
                samp_cnt      <= 7'd0;
                sym_cnt       <= 12'd0;
                state         <= (skip_eff == 10'd1) ? S_CP : S_SKIP;
            end else if (xfer) begin
                case (state)
                    S_IDLE: ;
                    S_SKIP: begin
                        if (skip_cnt == frame_skip - 10'd1) begin
                            state    <= S_CP;
                            samp_cnt <= 7'd0;
                        end else begin
                            skip_cnt <= skip_cnt + 10'd1;
                        end
                    end
                    S_CP: begin
                        if (samp_cnt == 7'(CP_LEN - 1)) begin
                            state    <= S_SYM;
                            samp_cnt <= 7'd0;
                        end else begin
                            samp_cnt <= samp_cnt + 7'd1;
                        end
                    end
                    S_SYM: begin
                        o_tvalid <= 1'b1;
                        o_tdata  <= i_tdata;
                        o_phase  <= phase_reg;
                        o_tlast  <= (samp_cnt == 7'(FFT_LEN - 1));
                        if (samp_cnt == 7'(FFT_LEN - 1)) begin
                            samp_cnt <= 7'd0;
                            sym_cnt  <= sym_cnt + 12'd1;
                            if (frame_num_sym != 12'd0 && sym_cnt + 12'd1 == frame_num_sym) begin
                                frame_done <= 1'b1;
                                state      <= S_IDLE;
                            end else begin
                                state <= S_CP;
                            end
                        end else begin
                            samp_cnt <= samp_cnt + 7'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef OFDM_SYMBOL_FRAMER_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_frames  <= 16'd0;
            stat_resyncs <= 16'd0;
        end else if (marker) begin
            if (stat_frames != 16'hFFFF) stat_frames <= stat_frames + 16'd1;
            if (state != S_IDLE && stat_resyncs != 16'hFFFF) stat_resyncs <= stat_resyncs + 16'd1;
        end
    end
`else
    assign stat_frames  = 16'd0;
    assign stat_resyncs = 16'd0;
`endif

endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// Scoreboard bench for ofdm_symbol_framer: random stimulus checked against a
// position-arithmetic frame model; a monitor pops expected beats on each output handshake.
module tb_ofdm_symbol_framer;
    localparam int EW  = 65;
    localparam int CP  = 16;
    localparam int FFT = 64;
    localparam int BLK = CP + FFT;

    logic        clk;
    logic        reset_n;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [31:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [31:0] phase_tdata;
    logic        phase_tvalid;
    logic        phase_tready;
    logic [31:0] o_tdata;
    logic [31:0] o_phase;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic        frame_done;
    logic [15:0] stat_frames;
    logic [15:0] stat_resyncs;

    ofdm_symbol_framer dut (
        .clk(clk), .reset_n(reset_n),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .phase_tdata(phase_tdata), .phase_tvalid(phase_tvalid), .phase_tready(phase_tready),
        .o_tdata(o_tdata), .o_phase(o_phase), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
        .o_tready(o_tready), .frame_done(frame_done),
        .stat_frames(stat_frames), .stat_resyncs(stat_resyncs)
    );

    // clock / reset
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    logic [EW-1:0] exp_q[$];

    // reference model state
    int          skip_set;
    int          num_set;
    bit          m_in_frame;
    int          m_pos;
    int          m_skip;
    int          m_num;
    logic [31:0] m_phase;
    int          m_frames;
    int          m_resyncs;
    int          fd_cyc = -100;

    bit hold_low = 0;
    bit rand_rdy = 0;
    bit gaps_en  = 0;

    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        skip_set   = 192;
        num_set    = 0;
        m_in_frame = 0;
        m_pos      = 0;
        m_frames   = 0;
        m_resyncs  = 0;
        fd_cyc     = -100;
    endtask

    task automatic model_accept(input logic [31:0] d, input logic last, input logic [31:0] ph);
        int q, sym, off;
        if (last) begin
            if (m_in_frame) m_resyncs++;
            m_frames++;
            m_in_frame = 1;
            m_pos      = 0;
            m_skip     = (skip_set == 0) ? 1 : skip_set;
            m_num      = num_set;
            m_phase    = ph;
        end else if (m_in_frame) begin
            m_pos++;
            if (m_pos >= m_skip) begin
                q   = m_pos - m_skip;
                sym = q / BLK;
                off = q % BLK;
                if (off >= CP) begin
                    exp_q.push_back({d, m_phase, off == BLK - 1});
                    if (off == BLK - 1 && m_num != 0 && sym == m_num - 1) begin
                        m_in_frame = 0;
                        fd_cyc     = cyc;
                    end
                end
            end
        end
    endtask

    // driver tasks (entered and left on a falling edge)
    task automatic stop_input();
        i_tvalid     = 1'b0;
        phase_tvalid = 1'b0;
        i_tlast      = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last, input logic [31:0] ph);
        int budget;
        if (gaps_en && $urandom_range(0, 3) == 0) begin
            i_tvalid     = $urandom_range(0, 1);
            phase_tvalid = ~i_tvalid;
            i_tlast      = $urandom_range(0, 1);
            i_tdata      = $urandom;
            phase_tdata  = $urandom;
            @(negedge clk);
        end
        i_tdata      = d;
        i_tlast      = last;
        phase_tdata  = ph;
        i_tvalid     = 1'b1;
        phase_tvalid = 1'b1;
        budget       = 0;
        forever begin
            #4;
            if (i_tready) begin
                model_accept(d, last, ph);
                @(negedge clk);
                break;
            end
            @(negedge clk);
            budget++;
            if (budget > 500) begin
                chk("input_accept_timeout", EW'(budget), EW'(0));
                break;
            end
        end
    endtask

    task automatic send_data(input int n);
        for (int i = 0; i < n; i++) send_beat($urandom, 1'b0, $urandom);
    endtask

    task automatic write_set(input logic [7:0] a, input logic [31:0] d);
        stop_input();
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        @(negedge clk);
        set_stb = 1'b0;
        if (a == 8'd6) skip_set = int'(d[9:0]);
        if (a == 8'd7) num_set = int'(d[11:0]);
    endtask

    task automatic wait_drain();
        int k;
        stop_input();
        rand_rdy = 0;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("drain_empty", EW'(exp_q.size()), EW'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic check_stats();
`ifdef OFDM_SYMBOL_FRAMER_STATS_EN
        chk("stat_frames", EW'(stat_frames), EW'(m_frames));
        chk("stat_resyncs", EW'(stat_resyncs), EW'(m_resyncs));
`else
        chk("stat_frames", EW'(stat_frames), EW'(0));
        chk("stat_resyncs", EW'(stat_resyncs), EW'(0));
`endif
    endtask

    task automatic check_reset_values();
        chk("rst_o_tvalid", EW'(o_tvalid), EW'(0));
        chk("rst_o_tlast", EW'(o_tlast), EW'(0));
        chk("rst_o_tdata", EW'(o_tdata), EW'(0));
        chk("rst_o_phase", EW'(o_phase), EW'(0));
        chk("rst_frame_done", EW'(frame_done), EW'(0));
        chk("rst_i_tready", EW'(i_tready), EW'(1));
        chk("rst_phase_tready", EW'(phase_tready), EW'(1));
        chk("rst_stat_frames", EW'(stat_frames), EW'(0));
        chk("rst_stat_resyncs", EW'(stat_resyncs), EW'(0));
    endtask

    // output ready pattern
    initial o_tready = 1'b1;
    always begin
        @(negedge clk);
        #1;
        if (hold_low)      o_tready = 1'b0;
        else if (rand_rdy) o_tready = 1'($urandom_range(0, 1));
        else               o_tready = 1'b1;
    end

    // monitor / scoreboard
    bit            prev_stall = 0;
    logic [EW-1:0] held;
    logic [EW-1:0] e;
    always begin
        @(negedge clk);
        #4;
        chk("frame_done", EW'(frame_done), EW'(cyc == fd_cyc + 1));
        if (prev_stall && o_tvalid) chk("stall_hold", {o_tdata, o_phase, o_tlast}, held);
        if (o_tvalid && o_tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", EW'(o_tvalid), EW'(0));
            end else begin
                e = exp_q.pop_front();
                chk("out_beat", {o_tdata, o_phase, o_tlast}, e);
            end
        end
        prev_stall = o_tvalid && !o_tready;
        held       = {o_tdata, o_phase, o_tlast};
    end

    int sk;

    initial begin
        reset_n  = 1'b0;
        set_stb  = 1'b0;
        set_addr = 8'd0;
        set_data = 32'd0;
        i_tdata  = 32'd0;
        phase_tdata = 32'd0;
        stop_input();
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values();
        reset_n = 1'b1;
        @(negedge clk);

        // default skip, two symbols, sample index as data
        write_set(8'd7, 32'd2);
        for (int i = 0; i < 3; i++) send_beat(32'hDEAD0000 + i, 1'b0, $urandom);
        send_beat(32'd0, 1'b1, 32'h01000000);
        for (int i = 1; i < 400; i++) send_beat(i, 1'b0, $urandom);
        wait_drain();

        // random backpressure and input gaps, random skip
        sk = $urandom_range(2, 40);
        write_set(8'd6, sk);
        write_set(8'd7, 32'd3);
        rand_rdy = 1;
        gaps_en  = 1;
        send_beat($urandom, 1'b1, $urandom);
        send_data(sk + 3 * BLK + 20);
        gaps_en = 0;
        wait_drain();

        // skip of 0 behaves as 1
        write_set(8'd6, 32'd0);
        write_set(8'd7, 32'd1);
        send_beat($urandom, 1'b1, 32'h00ABCDEF);
        send_data(BLK + 15);
        wait_drain();

        // resync at the 30th kept sample of the second symbol
        write_set(8'd6, 32'd5);
        write_set(8'd7, 32'd0);
        rand_rdy = 1;
        send_beat($urandom, 1'b1, 32'h11111111);
        send_data(129);
        send_beat($urandom, 1'b1, 32'h22222222);
        send_data(200);
        wait_drain();
        check_stats();

        // symbol count change mid-frame applies to the next frame
        write_set(8'd7, 32'd1);
        send_beat($urandom, 1'b1, $urandom);
        send_data(40);
        write_set(8'd7, 32'd3);
        send_data(60);
        send_beat($urandom, 1'b1, $urandom);
        send_data(5 + 3 * BLK + 10);
        wait_drain();
        check_stats();

        // asynchronous reset with an output beat pending
        write_set(8'd6, 32'd10);
        write_set(8'd7, 32'd0);
        send_beat($urandom, 1'b1, $urandom);
        send_data(36);
        stop_input();
        hold_low = 1;
        repeat (2) @(negedge clk);
        #2;
        chk("pre_reset_valid", EW'(o_tvalid), EW'(1));
        reset_n = 1'b0;
        #1;
        chk("async_clear_valid", EW'(o_tvalid), EW'(0));
        exp_q.delete();
        model_reset();
        @(negedge clk);
        check_reset_values();
        reset_n  = 1'b1;
        hold_low = 0;
        @(negedge clk);
        send_beat($urandom, 1'b1, 32'h0F0F0F0F);
        send_data(300);
        wait_drain();
        check_stats();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
